rom_boot_ctrl: RTL and testbench

Parametrised boot and program-ROM controller for the 68K side of the arcade core. It generalises the fixed 255-cycle reset stretch and the two-bank ROM mux into a single block. It has three parts:
- A power-on/soft reset sequencer that drives the CPU reset and the power-ready (PR1) signal.
- An N-bank synchronous ROM read port with bank decode.
- A 68K-style AS_b/DTACK_b handshake with programmable read latency and bus-error reporting.

It sits between the CPU bus (graphics/CPU block) and the block-RAM ROM images.

---
 rtl/rom_boot_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rom_boot_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_boot_ctrl.sv
// Boot/ROM controller for the 68K side: stretched CPU reset with power-ready,
// N-bank synchronous ROM read port, AS_b/DTACK_b handshake with bus-error path.
module rom_boot_ctrl #(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int BANK_LSB  = 18,
  parameter int BANK_AW   = 17,
  parameter int RST_HOLD  = 255,
  parameter int READ_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        soft_rst,
  input  logic                        as_b,
  input  logic                        br_w_b,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [NUM_BANKS*DATA_W-1:0] rom_rdata,
  output logic [BANK_AW-1:0]          rom_addr,
  output logic [NUM_BANKS-1:0]        rom_re,
  output logic [DATA_W-1:0]           data,
  output logic                        dtack_b,
  output logic                        berr_b,
  output logic                        cpu_rst_b,
  output logic                        pr1,
  output logic                        busy
);

  localparam int         BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [2:0]  LAT_LAST  = 3'(READ_LAT);

  typedef enum logic {S_HOLD, S_RUN} seq_e;
  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK, B_ERR} bus_e;

  seq_e                 seq_q, seq_d;
  logic [15:0]          hold_cnt_q, hold_cnt_d;
  logic                 cpu_rst_b_q, cpu_rst_b_d;
  logic                 pr1_q, pr1_d;
  bus_e                 bus_q, bus_d;
  logic [2:0]           lat_q, lat_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [NUM_BANKS-1:0] rom_re_q, rom_re_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 dtack_b_q, dtack_b_d;
  logic                 berr_b_q, berr_b_d;
  logic                 as_b_q;

  logic [BANK_W-1:0]    bank;
  logic                 bank_ok;
  logic                 as_fall;
  logic                 bus_en;
  logic [DATA_W-1:0]    rd_sel;
  logic                 unused_addr;

  assign bank        = addr[BANK_LSB +: BANK_W];
  assign bank_ok     = int'(bank) < NUM_BANKS;
  assign as_fall     = !as_b && as_b_q;
  assign rom_addr    = addr[BANK_AW-1:0];
  assign unused_addr = ^addr;
  // A soft reset request shuts the bus down on the same edge the sequencer re-enters HOLD.
  assign bus_en      = (seq_q == S_RUN) && !soft_rst;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_q == BANK_W'(k)) rd_sel = rom_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    seq_d       = seq_q;
    hold_cnt_d  = hold_cnt_q;
    cpu_rst_b_d = cpu_rst_b_q;
    pr1_d       = pr1_q;
    case (seq_q)
      S_HOLD: begin
        cpu_rst_b_d = 1'b0;
        if (soft_rst) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          seq_d       = S_RUN;
          hold_cnt_d  = '0;
          cpu_rst_b_d = 1'b1;
          pr1_d       = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      default: begin
        if (soft_rst) begin
          seq_d       = S_HOLD;
          hold_cnt_d  = '0;
          cpu_rst_b_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    bus_d     = bus_q;
    lat_d     = lat_q;
    bank_d    = bank_q;
    rom_re_d  = '0;
    data_d    = data_q;
    dtack_b_d = dtack_b_q;
    berr_b_d  = berr_b_q;
    if (!bus_en) begin
      bus_d     = B_IDLE;
      lat_d     = '0;
      bank_d    = '0;
      data_d    = '0;
      dtack_b_d = 1'b1;
      berr_b_d  = 1'b1;
    end else begin
      case (bus_q)
        B_IDLE: begin
          if (as_fall) begin
            if (br_w_b && bank_ok) begin
              bank_d = bank;
              lat_d  = '0;
              bus_d  = B_WAIT;
              for (int k = 0; k < NUM_BANKS; k++) begin
                rom_re_d[k] = (bank == BANK_W'(k));
              end
            end else begin
              bus_d = B_ERR;
            end
          end
        end
        B_WAIT: begin
          // Counter spans the rom_re issue cycle plus READ_LAT ROM cycles.
          if (as_b) begin
            bus_d = B_IDLE;
          end else if (lat_q == LAT_LAST) begin
            data_d    = rd_sel;
            dtack_b_d = 1'b0;
            bus_d     = B_ACK;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        B_ACK: begin
          if (as_b) begin
            dtack_b_d = 1'b1;
            bus_d     = B_IDLE;
          end
        end
        B_ERR: begin
          if (as_b) begin
            berr_b_d = 1'b1;
            bus_d    = B_IDLE;
          end else begin
            berr_b_d = 1'b0;
          end
        end
        default: bus_d = B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q       <= S_HOLD;
      hold_cnt_q  <= '0;
      cpu_rst_b_q <= 1'b0;
      pr1_q       <= 1'b0;
      bus_q       <= B_IDLE;
      lat_q       <= '0;
      bank_q      <= '0;
      rom_re_q    <= '0;
      data_q      <= '0;
      dtack_b_q   <= 1'b1;
      berr_b_q    <= 1'b1;
      as_b_q      <= 1'b1;
    end else begin
      seq_q       <= seq_d;
      hold_cnt_q  <= hold_cnt_d;
      cpu_rst_b_q <= cpu_rst_b_d;
      pr1_q       <= pr1_d;
      bus_q       <= bus_d;
      lat_q       <= lat_d;
      bank_q      <= bank_d;
      rom_re_q    <= rom_re_d;
      data_q      <= data_d;
      dtack_b_q   <= dtack_b_d;
      berr_b_q    <= berr_b_d;
      as_b_q      <= as_b;
    end
  end

  assign rom_re    = rom_re_q;
  assign data      = data_q;
  assign dtack_b   = dtack_b_q;
  assign berr_b    = berr_b_q;
  assign cpu_rst_b = cpu_rst_b_q;
  assign pr1       = pr1_q;
  assign busy      = (bus_q != B_IDLE);

endmodule

// File: tb/tb_rom_boot_ctrl.sv
// Bench for rom_boot_ctrl: three parameterisations share stimulus; a scoreboard
// queue holds expected bus responses, consumed by a monitor on dtack_b/berr_b falls.
module tb_rom_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, soft_rst, as_b, br_w_b;
  logic [22:0] addr;
  int          sel;
  int          cyc = 0;
  int          t_strobe;
  int          n_vec = 0;
  int          n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Only the selected instance sees strobes; the others stay idle.
  logic as_b0, as_b1, as_b2;
  assign as_b0 = (sel == 0) ? as_b : 1'b1;
  assign as_b1 = (sel == 1) ? as_b : 1'b1;
  assign as_b2 = (sel == 2) ? as_b : 1'b1;

  logic [16:0] rom_addr0, rom_addr1, rom_addr2;
  logic [1:0]  rom_re0, rom_re2;
  logic [2:0]  rom_re1;
  logic [15:0] data0, data1, data2;
  logic        dtack_b0, dtack_b1, dtack_b2, berr_b0, berr_b1, berr_b2;
  logic        cpu_rst_b0, cpu_rst_b1, cpu_rst_b2, pr1_0, pr1_1, pr1_2;
  logic        busy0, busy1, busy2;

  rom_boot_ctrl #(.NUM_BANKS(2), .READ_LAT(1), .RST_HOLD(255)) u0 (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .as_b(as_b0), .br_w_b(br_w_b),
    .addr(addr), .rom_rdata(32'hBEEF_1234), .rom_addr(rom_addr0), .rom_re(rom_re0),
    .data(data0), .dtack_b(dtack_b0), .berr_b(berr_b0), .cpu_rst_b(cpu_rst_b0),
    .pr1(pr1_0), .busy(busy0));

  rom_boot_ctrl #(.NUM_BANKS(3), .READ_LAT(3), .RST_HOLD(8)) u1 (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .as_b(as_b1), .br_w_b(br_w_b),
    .addr(addr), .rom_rdata(48'h5A5A_BEEF_1234), .rom_addr(rom_addr1), .rom_re(rom_re1),
    .data(data1), .dtack_b(dtack_b1), .berr_b(berr_b1), .cpu_rst_b(cpu_rst_b1),
    .pr1(pr1_1), .busy(busy1));

  rom_boot_ctrl #(.NUM_BANKS(2), .READ_LAT(4), .RST_HOLD(8)) u2 (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .as_b(as_b2), .br_w_b(br_w_b),
    .addr(addr), .rom_rdata(32'hCAFE_1234), .rom_addr(rom_addr2), .rom_re(rom_re2),
    .data(data2), .dtack_b(dtack_b2), .berr_b(berr_b2), .cpu_rst_b(cpu_rst_b2),
    .pr1(pr1_2), .busy(busy2));

  logic [16:0] s_rom_addr;
  logic [2:0]  s_rom_re;
  logic [15:0] s_data;
  logic        s_dtack_b, s_berr_b, s_cpu_rst_b, s_pr1, s_busy;

  always_comb begin
    s_rom_addr = rom_addr0; s_rom_re = {1'b0, rom_re0}; s_data = data0;
    s_dtack_b = dtack_b0; s_berr_b = berr_b0; s_cpu_rst_b = cpu_rst_b0;
    s_pr1 = pr1_0; s_busy = busy0;
    if (sel == 1) begin
      s_rom_addr = rom_addr1; s_rom_re = rom_re1; s_data = data1;
      s_dtack_b = dtack_b1; s_berr_b = berr_b1; s_cpu_rst_b = cpu_rst_b1;
      s_pr1 = pr1_1; s_busy = busy1;
    end else if (sel == 2) begin
      s_rom_addr = rom_addr2; s_rom_re = {1'b0, rom_re2}; s_data = data2;
      s_dtack_b = dtack_b2; s_berr_b = berr_b2; s_cpu_rst_b = cpu_rst_b2;
      s_pr1 = pr1_2; s_busy = busy2;
    end
  end

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    int          t0;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every falling dtack_b/berr_b must match the oldest expected response.
  logic prev_dt = 1'b1;
  logic prev_be = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_dt && !s_dtack_b) begin
        chk("dtack_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resp_kind_ack", 32'(e.is_err), 0);
          chk("dtack_cycle", cyc, e.t0 + e.lat);
          chk("read_data", s_data, e.data);
        end
      end
      if (prev_be && !s_berr_b) begin
        chk("berr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resp_kind_err", 32'(e.is_err), 1);
          chk("berr_cycle", cyc, e.t0 + e.lat);
        end
      end
    end
    prev_dt = s_dtack_b;
    prev_be = s_berr_b;
  end

  task automatic strobe(input logic [22:0] a, input logic rd);
    @(negedge clk);
    addr = a; br_w_b = rd; as_b = 1'b0;
    t_strobe = cyc + 1;
  endtask

  task automatic wait_dtack(input string nm);
    int n = 0;
    while (s_dtack_b !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_in_time"}, 32'(n < 40), 1);
  endtask

  task automatic release_and_check(input string nm, input logic [15:0] d);
    as_b = 1'b1;
    @(negedge clk);
    chk({nm, "_dtack_release"}, s_dtack_b, 1);
    chk({nm, "_busy_idle"}, s_busy, 0);
    chk({nm, "_data_kept"}, s_data, d);
  endtask

  task automatic err_case(input string nm, input logic [22:0] a, input logic rd);
    logic seen_re, seen_dt;
    seen_re = 1'b0; seen_dt = 1'b0;
    strobe(a, rd);
    exp_q.push_back('{1'b1, 16'h0, t_strobe, 1});
    repeat (3) begin
      @(negedge clk);
      seen_re |= |s_rom_re;
      seen_dt |= !s_dtack_b;
    end
    chk({nm, "_no_rom_re"}, seen_re, 0);
    chk({nm, "_no_dtack"}, seen_dt, 0);
    chk({nm, "_berr_held"}, s_berr_b, 0);
    as_b = 1'b1;
    @(negedge clk);
    chk({nm, "_berr_release"}, s_berr_b, 1);
    chk({nm, "_busy_idle"}, s_busy, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_cpu_rst_b"}, s_cpu_rst_b, 0);
    chk({nm, "_pr1"}, s_pr1, 0);
    chk({nm, "_dtack_b"}, s_dtack_b, 1);
    chk({nm, "_berr_b"}, s_berr_b, 1);
    chk({nm, "_rom_re"}, s_rom_re, 0);
    chk({nm, "_data"}, s_data, 0);
    chk({nm, "_busy"}, s_busy, 0);
  endtask

  initial begin
    int n, rise;
    reset = 1'b1; soft_rst = 1'b0; as_b = 1'b1; br_w_b = 1'b1; addr = '0; sel = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");

    // Power-on hold: cpu_rst_b/pr1 rise on the 255th edge after release.
    reset = 1'b0;
    n = 0; rise = 0;
    while (rise == 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 254) chk("pr1_before_hold_end", s_pr1, 0);
      if (s_cpu_rst_b) rise = n;
    end
    chk("hold_len", rise, 255);
    chk("pr1_after_hold", s_pr1, 1);

    // Bank-1 read, READ_LAT=1.
    strobe(23'h040010, 1'b1);
    exp_q.push_back('{1'b0, 16'hBEEF, t_strobe, 2});
    #1 chk("t2_rom_addr", s_rom_addr, 17'h00010);
    @(negedge clk); chk("t2_rom_re_pulse", s_rom_re, 3'b010);
    @(negedge clk); chk("t2_rom_re_clear", s_rom_re, 3'b000);
    wait_dtack("t2");
    @(negedge clk); chk("t2_ack_held", s_dtack_b, 0);
    release_and_check("t2", 16'hBEEF);

    // Bank-0 read, READ_LAT=3, three banks.
    @(negedge clk); sel = 1;
    strobe(23'h000005, 1'b1);
    exp_q.push_back('{1'b0, 16'h1234, t_strobe, 4});
    @(negedge clk); chk("t3_rom_re_pulse", s_rom_re, 3'b001);
    wait_dtack("t3");
    @(negedge clk);
    release_and_check("t3", 16'h1234);

    // Bus errors: a write, then a read of nonexistent bank 3.
    @(negedge clk); sel = 0;
    err_case("t4_write", 23'h000000, 1'b0);
    @(negedge clk); sel = 1;
    err_case("t4_bank3", 23'h0C0000, 1'b1);

    // Aborted read in WAIT (READ_LAT=4): no response may appear.
    @(negedge clk); sel = 2;
    strobe(23'h000020, 1'b1);
    @(negedge clk);
    @(negedge clk); chk("t5_busy_in_wait", s_busy, 1);
    as_b = 1'b1;
    @(negedge clk); chk("t5_abort_idle", s_busy, 0);
    repeat (6) @(negedge clk);
    chk("t5_no_dtack", s_dtack_b, 1);
    strobe(23'h040001, 1'b1);
    exp_q.push_back('{1'b0, 16'hCAFE, t_strobe, 5});
    wait_dtack("t5");
    @(negedge clk);
    release_and_check("t5", 16'hCAFE);

    // Soft reset while in ACK.
    @(negedge clk); sel = 0;
    strobe(23'h040010, 1'b1);
    exp_q.push_back('{1'b0, 16'hBEEF, t_strobe, 2});
    wait_dtack("t6");
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk("t6_dtack_b", s_dtack_b, 1);
    chk("t6_cpu_rst_b", s_cpu_rst_b, 0);
    chk("t6_pr1", s_pr1, 1);
    chk("t6_data", s_data, 0);
    as_b = 1'b1;
    n = 0; rise = 0;
    while (rise == 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (s_cpu_rst_b) rise = n;
    end
    chk("t6_soft_hold_len", rise, 255);
    chk("t6_pr1_kept", s_pr1, 1);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk); sel = 2;
    strobe(23'h000003, 1'b1);
    @(negedge clk);
    @(negedge clk); chk("t7_busy_in_wait", s_busy, 1);
    #3 reset = 1'b1;
    #1 check_reset_vals("t7_async");
    as_b = 1'b1;
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
